// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management port between the retune sequencer and the PLL reconfig controller.
interface pll_reconfig_seq_if;
    logic [5:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (output address, write, writedata, input waitrequest);
    modport slave  (input address, write, writedata, output waitrequest);
endinterface

// File: rtl/pll_reconfig_seq.sv
// Retunes the system PLL between NTSC and PAL master clocks when the standard select changes,
// then waits for a stable re-lock and reports done or a lock timeout.
//   state     | meaning
//   IDLE      | waiting for pal != cur_mode with PLL locked
//   WR_MODE   | write mode register (waitrequest mode)
//   WR_M      | write M counter
//   WR_C      | write C0 counter
//   WR_K      | write fractional K for the target standard
//   WR_START  | write start register
//   WAIT_RCFG | wait for reconfig controller to release waitrequest
//   WAIT_LOCK | count consecutive locked cycles
//   DONE      | commit cur_mode, pulse done
module pll_reconfig_seq #(
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pal,
    input  logic               pll_locked,
    pll_reconfig_seq_if.master mgmt,
    output logic               busy,
    output logic               cur_mode,
    output logic               done,
    output logic               lock_err
);
    localparam logic [31:0] M_VAL  = 32'h0000_0404;
    localparam logic [31:0] C0_VAL = 32'h0000_0404;
    localparam logic [31:0] K_NTSC = 32'd2537930535;
    localparam logic [31:0] K_PAL  = 32'd2201376898;
    localparam int STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_M, WR_C, WR_K, WR_START, WAIT_RCFG, WAIT_LOCK, DONE
    } state_t;

    state_t            state, state_nxt;
    logic              tgt;
    logic [STAB_W-1:0] stab_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              wr_done, timeout, trig, fin_err;
    logic              wr_nxt;
    logic [5:0]        addr_nxt;
    logic [31:0]       data_nxt;

    assign wr_done = mgmt.write && !mgmt.waitrequest;
    assign timeout = (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        trig      = 1'b0;
        fin_err   = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = mgmt.address;
        data_nxt  = mgmt.writedata;
        case (state)
            IDLE: begin
                if (pll_locked && (pal != cur_mode)) begin
                    state_nxt = WR_MODE;
                    trig      = 1'b1;
                end
            end
            WR_MODE:  if (wr_done) state_nxt = WR_M;
            WR_M:     if (wr_done) state_nxt = WR_C;
            WR_C:     if (wr_done) state_nxt = WR_K;
            WR_K:     if (wr_done) state_nxt = WR_START;
            WR_START: if (wr_done) state_nxt = WAIT_RCFG;
            WAIT_RCFG: begin
                if (timeout) begin
                    state_nxt = IDLE;
                    fin_err   = 1'b1;
                end else if (!mgmt.waitrequest) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock that stabilises on the final allowed cycle counts as success.
                if (pll_locked && (stab_cnt == STAB_LAST)) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    fin_err   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Bus outputs are registered from the next state so write rises on the trigger edge.
        case (state_nxt)
            WR_MODE:  begin wr_nxt = 1'b1; addr_nxt = 6'd0; data_nxt = 32'd0;  end
            WR_M:     begin wr_nxt = 1'b1; addr_nxt = 6'd4; data_nxt = M_VAL;  end
            WR_C:     begin wr_nxt = 1'b1; addr_nxt = 6'd5; data_nxt = C0_VAL; end
            WR_K:     begin wr_nxt = 1'b1; addr_nxt = 6'd7; data_nxt = tgt ? K_PAL : K_NTSC; end
            WR_START: begin wr_nxt = 1'b1; addr_nxt = 6'd2; data_nxt = 32'd0;  end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tgt            <= 1'b0;
            stab_cnt       <= '0;
            to_cnt         <= '0;
            mgmt.write     <= 1'b0;
            mgmt.address   <= 6'd0;
            mgmt.writedata <= 32'd0;
            busy           <= 1'b0;
            cur_mode       <= 1'b0;
            done           <= 1'b0;
            lock_err       <= 1'b0;
        end else begin
            state          <= state_nxt;
            mgmt.write     <= wr_nxt;
            mgmt.address   <= addr_nxt;
            mgmt.writedata <= data_nxt;
            done           <= (state_nxt == DONE);

            if (trig) begin
                tgt      <= pal;
                lock_err <= 1'b0;
                busy     <= 1'b1;
            end
            if (state_nxt == DONE) begin
                cur_mode <= tgt;
                busy     <= 1'b0;
            end
            if (fin_err) begin
                lock_err <= 1'b1;
                busy     <= 1'b0;
            end

            if (state == WR_START && wr_done) begin
                to_cnt <= '0;
            end else if (state == WAIT_RCFG || state == WAIT_LOCK) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (state != WAIT_LOCK || !pll_locked) begin
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected management writes are queued at stimulus
// time and matched as writes complete; done/lock_err timing is checked against cycle counts.
module tb_pll_reconfig_seq;
    localparam int unsigned LOCK_STABLE  = 256;
    localparam int unsigned LOCK_TIMEOUT = 2000;
    localparam logic [31:0] K_NTSC = 32'd2537930535;
    localparam logic [31:0] K_PAL  = 32'd2201376898;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pal = 1'b0;
    logic pll_locked = 1'b0;
    logic busy, cur_mode, done, lock_err;

    pll_reconfig_seq_if mgmt();

    pll_reconfig_seq #(.LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .pal(pal), .pll_locked(pll_locked), .mgmt(mgmt),
        .busy(busy), .cur_mode(cur_mode), .done(done), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
    wr_t sb_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_total = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0, k7_cnt = 0;
    int first_wr_cyc = 0, start_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_seq(input logic k_pal);
        sb_q.push_back('{6'd0, 32'd0});
        sb_q.push_back('{6'd4, 32'h0000_0404});
        sb_q.push_back('{6'd5, 32'h0000_0404});
        sb_q.push_back('{6'd7, k_pal ? K_PAL : K_NTSC});
        sb_q.push_back('{6'd2, 32'd0});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        chk("done_wait", done_cnt, d0 + 1);
    endtask

    task automatic wait_start(input int budget);
        int s0 = start_cnt;
        for (int i = 0; i < budget && start_cnt == s0; i++) @(negedge clk);
        chk("start_wait", start_cnt, s0 + 1);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mgmt.write) begin
                if (mgmt.address == 6'd7) k7_cnt++;
                if (!mgmt.waitrequest) begin
                    wr_t e;
                    wr_total++;
                    chk("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("wr_addr", mgmt.address, e.addr);
                        chk("wr_data", mgmt.writedata, e.data);
                    end
                    if (mgmt.address == 6'd0) first_wr_cyc = cyc;
                    if (mgmt.address == 6'd2) begin
                        start_cyc = cyc;
                        start_cnt++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_err_excl", lock_err, 0);
            end
            if (lock_err && !err_prev) begin
                err_cnt++;
                err_cyc = cyc;
            end
            err_prev = lock_err;
        end else begin
            err_prev = 1'b0;
        end
    end

    initial begin
        int t, p;
        mgmt.waitrequest = 1'b0;
        pll_locked = 1'b1;
        #23;
        chk("rst_addr", mgmt.address, 0);
        chk("rst_write", mgmt.write, 0);
        chk("rst_data", mgmt.writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", lock_err, 0);
        tick(1);
        rst_n = 1'b1;

        // Idle with matching standard: nothing happens
        tick(50);
        chk("idle_writes", wr_total, 0);
        chk("idle_busy", busy, 0);
        chk("idle_mode", cur_mode, 0);

        // NTSC -> PAL, no stalls
        push_seq(1'b1);
        t = cyc;
        pal = 1'b1;
        tick(1);
        chk("trig_busy", busy, 1);
        wait_done(400);
        chk("pal_first_wr", first_wr_cyc, t + 1);
        chk("pal_consec", start_cyc - first_wr_cyc, 4);
        chk("pal_done_lat", done_cyc - start_cyc, 258);
        tick(1);
        chk("pal_mode", cur_mode, 1);
        chk("pal_busy", busy, 0);
        chk("pal_sb_empty", sb_q.size(), 0);

        // PAL -> NTSC with lock dropping for 10 cycles mid WAIT_LOCK
        tick(5);
        push_seq(1'b0);
        pal = 1'b0;
        wait_start(50);
        tick(50);
        p = cyc;
        pll_locked = 1'b0;
        tick(10);
        pll_locked = 1'b1;
        wait_done(400);
        chk("drop_done_lat", done_cyc, p + 266);
        tick(1);
        chk("ntsc_mode", cur_mode, 0);

        // NTSC -> PAL with 3 stall cycles during the K write
        tick(5);
        push_seq(1'b1);
        k7_cnt = 0;
        pal = 1'b1;
        for (int i = 0; i < 20 && !(mgmt.write && mgmt.address == 6'd7); i++) tick(1);
        chk("stall_in_wrk", mgmt.address, 7);
        mgmt.waitrequest = 1'b1;
        tick(3);
        mgmt.waitrequest = 1'b0;
        wait_done(400);
        chk("stall_k7_cycles", k7_cnt, 4);
        chk("stall_span", start_cyc - first_wr_cyc, 7);
        chk("stall_sb_empty", sb_q.size(), 0);
        tick(1);
        chk("stall_mode", cur_mode, 1);

        // PAL -> NTSC with lock lost: timeout, then retry
        tick(5);
        push_seq(1'b0);
        pal = 1'b0;
        tick(1);
        pll_locked = 1'b0;
        wait_start(50);
        for (int i = 0; i < LOCK_TIMEOUT + 100 && err_cnt == 0; i++) @(negedge clk);
        chk("to_err_seen", err_cnt, 1);
        chk("to_err_lat", err_cyc - start_cyc, LOCK_TIMEOUT + 1);
        chk("to_busy", busy, 0);
        chk("to_mode", cur_mode, 1);
        tick(20);
        chk("to_err_sticky", lock_err, 1);
        push_seq(1'b0);
        pll_locked = 1'b1;
        tick(1);
        chk("retry_err_clr", lock_err, 0);
        wait_done(400);
        tick(1);
        chk("retry_mode", cur_mode, 0);

        // Reset during WR_M of a PAL retune, then full rerun
        tick(5);
        push_seq(1'b1);
        pal = 1'b1;
        for (int i = 0; i < 20 && !(mgmt.write && mgmt.address == 6'd4); i++) tick(1);
        chk("rst_in_wrm", mgmt.address, 4);
        rst_n = 1'b0;
        #1;
        chk("arst_write", mgmt.write, 0);
        chk("arst_addr", mgmt.address, 0);
        chk("arst_data", mgmt.writedata, 0);
        chk("arst_busy", busy, 0);
        sb_q.delete();
        tick(3);
        push_seq(1'b1);
        rst_n = 1'b1;
        wait_done(400);
        chk("rerun_consec", start_cyc - first_wr_cyc, 4);
        tick(1);
        chk("rerun_mode", cur_mode, 1);
        chk("final_sb_empty", sb_q.size(), 0);
        chk("final_wr_total", wr_total, 31);
        chk("final_done_cnt", done_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
